// File: rtl/inst_fetch.sv
// inst_fetch: instruction memory plus prefetch queue feeding decode with {pc, inst}.
// Latency: a read issued at edge E is pushed at E+1 and is visible on out_* after that edge.
// Backpressure: out_ready low holds the head stable; reads stop once queue plus in-flight reaches QDEPTH.
//
// Ports:
//   clk, rst                 sole clock (rising edge), synchronous active-high reset
//   load_en, load_data       instruction memory load strobe / word, one word per cycle
//   go                       start fetching from pc 0 (only honoured in IDLE)
//   redirect, redirect_pc    taken branch/jump from execute (only honoured in FETCH)
//   out_valid/out_ready      valid-ready handshake towards decode
//   out_inst, out_pc         head of the prefetch queue
//   busy                     high while in LOAD
// Optional feature macro: INST_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.

// Small generic FIFO used for the prefetch queue.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full without popping.
module inst_fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    // Storage carries no reset; the head is qualified by head_vld.
    always_ff @(posedge clk) begin
        if (push_vld && !rst && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;
endmodule

module inst_fetch #(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [15:0] load_data,
    input  logic        go,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_inst,
    output logic [7:0]  out_pc,
    output logic        busy
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0] imem [256];
    logic [7:0]  load_addr;
    logic [7:0]  wr_addr;
    logic [7:0]  fetch_pc;

    // One read can be in flight: its data sits in rd_inst for one cycle.
    logic        rd_vld;
    logic [7:0]  rd_pc;
    logic [15:0] rd_inst;

    logic        in_fetch;
    logic        redir_take;
    logic        flush;
    logic        rd_issue;
    logic        push;
    logic        pop;
    logic [OW-1:0] occupancy;

    logic          q_vld;
    logic [23:0]   q_head;
    logic [CW-1:0] q_cnt;

    // ---------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------
    assign in_fetch   = (state_q == ST_FETCH);
    assign redir_take = in_fetch && redirect && !load_en;
    // A load or a taken redirect throws away everything prefetched so far.
    assign flush      = load_en || redir_take;

    // Entries already queued plus the read in flight must leave room for a new read.
    assign occupancy  = {1'b0, q_cnt} + OW'(rd_vld);
    assign rd_issue   = in_fetch && !flush && (occupancy < OW'(QDEPTH));

    assign push       = rd_vld && !flush;
    // A pop in a flushing cycle is ignored: the queue is emptied instead.
    assign pop        = q_vld && out_ready && !flush;

    // Fresh load sessions start at address 0; continued LOAD cycles use load_addr.
    assign wr_addr    = (state_q == ST_LOAD) ? load_addr : 8'h00;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:  state_d = ST_IDLE;
                ST_IDLE:  state_d = go ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_d = ST_FETCH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_LOAD);

    // ---------------------------------------------------------------
    // Instruction memory: written by load, read one cycle after issue.
    // Contents survive reset; a write coinciding with rst is dropped.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load_en && !rst) begin
            imem[wr_addr] <= load_data;
        end
        if (rd_issue) begin
            rd_inst <= imem[fetch_pc];
        end
    end

    // ---------------------------------------------------------------
    // Load address, fetch pc and in-flight tracking
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            load_addr <= 8'h00;
            fetch_pc  <= 8'h00;
            rd_vld    <= 1'b0;
            rd_pc     <= 8'h00;
        end else begin
            if (load_en) begin
                load_addr <= wr_addr + 8'h01;
            end

            if (load_en) begin
                fetch_pc <= 8'h00;
            end else if (redir_take) begin
                fetch_pc <= redirect_pc;
            end else if ((state_q == ST_IDLE) && go) begin
                fetch_pc <= 8'h00;
            end else if (rd_issue) begin
                fetch_pc <= fetch_pc + 8'h01;
            end

            rd_vld <= rd_issue;
            if (rd_issue) begin
                rd_pc <= fetch_pc;
            end
        end
    end

    // ---------------------------------------------------------------
    // Prefetch queue
    // ---------------------------------------------------------------
    inst_fetch_fifo #(
        .WIDTH (24),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_vld (push),
        .push_dat ({rd_pc, rd_inst}),
        .pop_rdy  (pop),
        .head_vld (q_vld),
        .head_dat (q_head),
        .count    (q_cnt)
    );

    // Outputs read zero whenever nothing is presented.
    assign out_valid = q_vld;
    assign out_pc    = q_vld ? q_head[23:16] : 8'h00;
    assign out_inst  = q_vld ? q_head[15:0]  : 16'h0000;

`ifdef INST_FETCH_PERF_EN
    // ---------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || load_en) begin
            perf_fetch_cnt <= 16'h0000;
            perf_stall_cnt <= 16'h0000;
        end else begin
            if (pop && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'h0001;
            end
            if (q_vld && !out_ready && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'h0001;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus randomized traffic, all
// checked against a queue-based behavioural model of the fetch unit.
module tb_inst_fetch;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [15:0] load_data;
    logic        go;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [7:0]  out_pc;
    logic        busy;
`ifdef INST_FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    inst_fetch #(.QDEPTH(QD)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_data   (load_data),
        .go          (go),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .busy        (busy)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: mode 0 idle, 1 load, 2 fetch.
    // mq holds delivered-ready {pc,inst}; mfly holds reads issued last cycle.
    // ---------------------------------------------------------------
    int          mmode;
    logic [15:0] mmem [256];
    logic [23:0] mq [$];
    logic [23:0] mfly [$];
    logic [7:0]  mpc;
    logic [7:0]  maddr;
    logic [7:0]  ma;
    int          occ;

    always @(posedge clk) begin
        if (rst) begin
            mmode = 0; mpc = 8'h00; maddr = 8'h00;
            mq.delete(); mfly.delete();
        end else if (load_en) begin
            ma = (mmode == 1) ? maddr : 8'h00;
            mmem[ma] = load_data;
            maddr = ma + 8'h01;
            mq.delete(); mfly.delete();
            mpc = 8'h00;
            mmode = 1;
        end else if (mmode == 1) begin
            mmode = 0;
        end else if (mmode == 0) begin
            if (go) begin
                mmode = 2;
                mpc = 8'h00;
            end
        end else begin
            if (redirect) begin
                mq.delete(); mfly.delete();
                mpc = redirect_pc;
            end else begin
                occ = mq.size() + mfly.size();
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                while (mfly.size() > 0) mq.push_back(mfly.pop_front());
                if (occ < QD) begin
                    mfly.push_back({mpc, mmem[mpc]});
                    mpc = mpc + 8'h01;
                end
            end
        end
    end

    // Compare process: outputs only change on the rising edge, so the falling edge is safe.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_busy", busy, (mmode == 1));
            chk("m_valid", out_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_pc", out_pc, mq[0][23:16]);
                chk("m_inst", out_inst, mq[0][15:0]);
            end
        end
    end

    logic [15:0] words [256];
    logic [15:0] old2, old3;

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: out_valid=%b after %0d cycles, required 1", nm, out_valid, n);
        end
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_data = 16'h0; go = 1'b0;
        redirect = 1'b0; redirect_pc = 8'h0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = 16'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_busy", busy, 0);
        chk_on = 1'b1;
        rst = 1'b0;

        // Fill the whole memory; words 0..7 are 1001..1008
        for (int i = 0; i < 256; i++) begin
            words[i] = (i < 8) ? (16'h1001 + 16'(i)) : 16'($urandom);
            load_en = 1'b1;
            load_data = words[i];
            @(negedge clk);
            if (i == 0) chk("busy_in_load", busy, 1);
        end
        load_en = 1'b0;
        @(negedge clk);
        chk("busy_after_load", busy, 0);

        // Straight-line fetch, no bubbles
        go = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("go_e0_valid", out_valid, 0);
        @(negedge clk);
        chk("go_e1_valid", out_valid, 0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("seq_valid", out_valid, 1);
            chk("seq_pc", out_pc, k);
            chk("seq_inst", out_inst, 16'h1001 + 16'(k));
            if (k == 7) out_ready = 1'b0;
            @(negedge clk);
        end

        // Stall: head holds for 10 cycles
        for (int k = 0; k < 10; k++) begin
            chk("stall_pc", out_pc, 8'h07);
            chk("stall_inst", out_inst, 16'h1008);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 7; k < 13; k++) begin
            chk("release_pc", out_pc, k);
            chk("release_inst", out_inst, words[k]);
            @(negedge clk);
        end

        // Redirect with a full queue
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("full_valid", out_valid, 1);
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        chk("redir_e0_valid", out_valid, 0);
        @(negedge clk);
        chk("redir_e1_valid", out_valid, 0);
        @(negedge clk);
        chk("redir_e2_valid", out_valid, 1);
        chk("redir_e2_pc", out_pc, 8'h40);
        chk("redir_e2_inst", out_inst, words[8'h40]);

        // Wrap of the fetch pc
        out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 8'hFE;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("wrap_wait");
        for (int k = 0; k < 4; k++) begin
            ma = 8'hFE + 8'(k);
            chk("wrap_pc", out_pc, ma);
            chk("wrap_inst", out_inst, words[ma]);
            @(negedge clk);
        end

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            out_ready   = ($urandom_range(0, 99) < 70);
            redirect    = (r < 5);
            redirect_pc = 8'($urandom);
            go          = (r >= 5 && r < 15);
            load_en     = (r == 15 || r == 16);
            load_data   = 16'($urandom);
            rst         = (r == 17);
            @(negedge clk);
        end
        load_en = 1'b0; go = 1'b0; redirect = 1'b0; rst = 1'b0;

        // Load + redirect together in FETCH, then reset mid-LOAD
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; go = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_load_valid", out_valid, 1);
        old2 = mmem[2];
        old3 = mmem[3];
        load_en = 1'b1; redirect = 1'b1; redirect_pc = 8'h33; go = 1'b1; load_data = 16'hBEEF;
        @(negedge clk);
        chk("ld_redir_busy", busy, 1);
        chk("ld_redir_valid", out_valid, 0);
        redirect = 1'b0; go = 1'b0; load_data = 16'hCAFE;
        @(negedge clk);
        chk("ld2_busy", busy, 1);
        load_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ld_rst_busy", busy, 0);
        chk("ld_rst_valid", out_valid, 0);
        go = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_valid("after_rst_wait");
        chk("keep_pc0", out_pc, 0);
        chk("keep_inst0", out_inst, 16'hBEEF);
        @(negedge clk);
        chk("keep_inst1", out_inst, 16'hCAFE);
        @(negedge clk);
        chk("keep_inst2", out_inst, old2);
        @(negedge clk);
        chk("keep_inst3", out_inst, old3);

`ifdef INST_FETCH_PERF_EN
        // 3 stall cycles then 5 transfers
        load_en = 1'b1; load_data = 16'hBEEF;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        go = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        go = 1'b0;
        wait_valid("perf_wait");
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("perf_fetch", perf_fetch_cnt, 5);
        chk("perf_stall", perf_stall_cnt, 3);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, prefetch queue depth in entries (legal: 2, 4, 8).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port load_en, input, 1, instruction-memory load strobe, one word per cycle.
REQ-005 SHALL have port load_data, input, 16, instruction word to load.
REQ-006 SHALL have port go, input, 1, single-cycle pulse to start fetching from PC 0.
REQ-007 SHALL have port redirect, input, 1, branch/jump taken from execute stage.
REQ-008 SHALL have port redirect_pc, input, 8, new fetch target.
REQ-009 SHALL have port out_ready, input, 1, decode stage accepts the presented instruction.
REQ-010 SHALL have port out_valid, output, 1, out_inst/out_pc valid.
REQ-011 SHALL have port out_inst, output, 16, instruction to decode.
REQ-012 SHALL have port out_pc, output, 8, address of out_inst.
REQ-013 SHALL have port busy, output, 1, high in LOAD state.

Function
REQ-014 SHALL contain a 256x16 instruction memory, synchronous read, 1-cycle read latency.
REQ-015 SHALL implement states IDLE, LOAD, FETCH; transitions: any->LOAD on load_en; LOAD->IDLE on load_en low; IDLE->FETCH on go; FETCH stays until load_en.
REQ-016 LOAD: each load_en cycle SHALL write load_data to imem[load_addr] and increment load_addr, wrapping 255->0; load_addr SHALL return to 0 on entry to LOAD from IDLE/FETCH.
REQ-017 Any load_en cycle SHALL flush the queue, discard in-flight reads, and set fetch_pc to 0; load_en SHALL win over redirect and go.
REQ-018 go in IDLE SHALL set fetch_pc to 0; go in other states SHALL be ignored.
REQ-019 FETCH: a read SHALL issue each cycle that queue count plus in-flight reads < QDEPTH, then fetch_pc increments, wrapping 255->0.
REQ-020 Read data SHALL be pushed with its PC into a QDEPTH-entry FIFO; head drives out_inst/out_pc; out_valid = queue non-empty.
REQ-021 Transfer SHALL occur when out_valid & out_ready; the head is popped at that edge.
REQ-022 While out_valid & !out_ready, out_inst/out_pc SHALL hold stable.
REQ-023 Simultaneous push and pop with a full queue SHALL be legal and keep count unchanged.
REQ-024 redirect in FETCH SHALL flush the queue, discard any in-flight read, set fetch_pc to redirect_pc; a pop in that cycle SHALL be ignored.
REQ-025 After redirect sampled at edge E0: out_valid=0 after E0; read of redirect_pc issued at E1; out_valid=1 with out_pc=redirect_pc after E2.
REQ-026 Steady state with out_ready=1 SHALL sustain one instruction per cycle.
REQ-027 redirect outside FETCH SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE, fetch_pc=0, load_addr=0, queue empty, in-flight cleared, out_valid=0, out_inst=0, out_pc=0, busy=0.
REQ-029 rst mid-LOAD or mid-FETCH SHALL abort the operation; imem contents SHALL be retained.

Configuration
REQ-030 With macro INST_FETCH_PERF_EN defined: SHALL add outputs perf_fetch_cnt (16) counting transfers and perf_stall_cnt (16) counting out_valid & !out_ready cycles, both saturating at 16'hFFFF and cleared by rst or load_en.
REQ-031 Without INST_FETCH_PERF_EN: those ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-032 Load 16'h1001..16'h1008 at addr 0-7, go, out_ready=1 -> out_pc 0..7 consecutive cycles, out_inst 16'h1001..16'h1008, no bubbles.
REQ-033 Hold out_ready=0 for 10 cycles in FETCH -> queue fills to QDEPTH, out_pc/out_inst stable, no read issued; release -> in-order delivery with no loss.
REQ-034 redirect with redirect_pc=8'h40 while queue full -> out_valid=0 after E0, out_pc=8'h40 valid after E2, no stale entry delivered.
REQ-035 Fetch from pc 8'hFE with out_ready=1 -> out_pc FE, FF, 00, 01.
REQ-036 Assert load_en and redirect in the same FETCH cycle, then rst mid-LOAD -> LOAD entered, redirect ignored; after rst state IDLE, out_valid=0, prior imem words intact.
REQ-037 With INST_FETCH_PERF_EN: 5 transfers plus 3 stall cycles -> perf_fetch_cnt=5, perf_stall_cnt=3.
